// File: rtl/bayer_to_gray.sv
// bayer_to_gray: collapses each 2x2 GRBG quad of a raw Bayer stream into one gray pixel.
//
// Ports:
//   iCLK   pipeline clock
//   iRST   synchronous active-high reset
//   iDATA  raw Bayer pixel, qualified by iDVAL
//   iDVAL  raw pixel valid (gaps allowed, gaps stall all state)
//   iSOF   start-of-frame, realigns column/row counters to (0,0)
//   oDATA  gray pixel, holds its value between pulses
//   oDVAL  one-cycle pulse per completed quad
//   oEOF   high with the oDVAL of the last quad of a frame
//
// Build option: define BAYER_GREEN_ONLY_EN to output (G1 + G2) / 2 instead of the
// four-pixel average. The line buffer and timing are identical in both builds.
module bayer_to_gray #(
  parameter int unsigned IMG_WIDTH  = 1280,
  parameter int unsigned IMG_HEIGHT = 960,
  parameter int unsigned DATA_W     = 12
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [DATA_W-1:0] iDATA,
  input  logic              iDVAL,
  input  logic              iSOF,
  output logic [DATA_W-1:0] oDATA,
  output logic              oDVAL,
  output logic              oEOF
);

  localparam int unsigned ColW = $clog2(IMG_WIDTH);
  localparam int unsigned RowW = $clog2(IMG_HEIGHT);
  localparam logic [ColW-1:0] ColLast = ColW'(IMG_WIDTH - 1);
  localparam logic [RowW-1:0] RowLast = RowW'(IMG_HEIGHT - 1);

  // Position counters
  logic [ColW-1:0] col_q, col_d, cur_col;
  logic [RowW-1:0] row_q, row_d, cur_row;

  // Held pixels: previous current-row pixel and previous above pixel
  logic [DATA_W-1:0] cur_hold_q;
  logic [DATA_W-1:0] above_hold_q;

  // One line of even-row pixels; never reset, row 0 of each frame refills it
  logic [DATA_W-1:0] lb_mem [IMG_WIDTH];
  logic [DATA_W-1:0] lb_rd;

  logic              quad_done;
  logic              eof_hit;
  logic [DATA_W-1:0] gray;

  logic [DATA_W-1:0] data_q;
  logic              dval_q;
  logic              eof_q;

  // A beat carrying iSOF is itself column 0, row 0.
  always_comb begin
    cur_col = iSOF ? '0 : col_q;
    cur_row = iSOF ? '0 : row_q;
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (iDVAL) begin
      if (cur_col == ColLast) begin
        col_d = '0;
        row_d = (cur_row == RowLast) ? '0 : cur_row + RowW'(1);
      end else begin
        col_d = cur_col + ColW'(1);
        row_d = cur_row;
      end
    end else if (iSOF) begin
      col_d = '0;
      row_d = '0;
    end
  end

  assign lb_rd     = lb_mem[cur_col];
  assign quad_done = iDVAL && cur_row[0] && cur_col[0];
  assign eof_hit   = quad_done && (cur_row == RowLast) && (cur_col == ColLast);

  // On the odd/odd beat: G1 = held above, R = above now, B = held current, G2 = iDATA.
`ifdef BAYER_GREEN_ONLY_EN
  logic [DATA_W:0] green_sum;
  always_comb begin
    green_sum = {1'b0, above_hold_q} + {1'b0, iDATA};
    gray      = green_sum[DATA_W:1];
  end
`else
  logic [DATA_W+1:0] quad_sum;
  always_comb begin
    quad_sum = {2'b00, above_hold_q} + {2'b00, lb_rd} + {2'b00, cur_hold_q} + {2'b00, iDATA};
    gray     = quad_sum[DATA_W+1:2];
  end
`endif

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      col_q        <= '0;
      row_q        <= '0;
      cur_hold_q   <= '0;
      above_hold_q <= '0;
      data_q       <= '0;
      dval_q       <= 1'b0;
      eof_q        <= 1'b0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      dval_q <= quad_done;
      eof_q  <= eof_hit;
      if (iDVAL) begin
        cur_hold_q   <= iDATA;
        above_hold_q <= lb_rd;
      end
      if (quad_done) begin
        data_q <= gray;
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRST && iDVAL && !cur_row[0]) begin
      lb_mem[cur_col] <= iDATA;
    end
  end

  assign oDATA = data_q;
  assign oDVAL = dval_q;
  assign oEOF  = eof_q;

endmodule

// File: tb/tb_bayer_to_gray.sv
module tb_bayer_to_gray;

  localparam int W = 4;
  localparam int H = 4;

  logic        clk;
  logic        rst;
  logic [11:0] idata;
  logic        idval;
  logic        isof;
  logic [11:0] odata;
  logic        odval;
  logic        oeof;

  bayer_to_gray #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .DATA_W    (12)
  ) dut (
    .iCLK (clk),
    .iRST (rst),
    .iDATA(idata),
    .iDVAL(idval),
    .iSOF (isof),
    .oDATA(odata),
    .oDVAL(odval),
    .oEOF (oeof)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int     data;
    bit     eof;
    longint at;
  } exp_t;

  exp_t exp_q[$];
  int   out_log[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: a picture of the current frame plus the beat position.
  int pix[H][W];
  int m_col = 0;
  int m_row = 0;

  task automatic chk(input string name, input longint act, input longint req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_step(input int d, input bit v, input bit s, input bit r);
    int c, rr, g1, rd, bl, g2;
    exp_t e;
    if (r) begin
      m_col = 0;
      m_row = 0;
      return;
    end
    if (v) begin
      c  = s ? 0 : m_col;
      rr = s ? 0 : m_row;
      pix[rr][c] = d;
      if ((rr % 2 == 1) && (c % 2 == 1)) begin
        g1 = pix[rr-1][c-1];
        rd = pix[rr-1][c];
        bl = pix[rr][c-1];
        g2 = d;
`ifdef BAYER_GREEN_ONLY_EN
        e.data = (g1 + g2) / 2;
`else
        e.data = (g1 + rd + bl + g2) / 4;
`endif
        e.eof = (rr == H - 1) && (c == W - 1);
        e.at  = cyc + 1;
        exp_q.push_back(e);
      end
      c = c + 1;
      if (c == W) begin
        c  = 0;
        rr = (rr + 1) % H;
      end
      m_col = c;
      m_row = rr;
    end else if (s) begin
      m_col = 0;
      m_row = 0;
    end
  endtask

  task automatic drive(input logic [11:0] d, input bit v, input bit s, input bit r);
    @(posedge clk);
    #1;
    idata = d;
    idval = v;
    isof  = s;
    rst   = r;
    model_step(int'(d), v, s, r);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(12'h000, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic reset_dut();
    drive(12'h000, 1'b0, 1'b0, 1'b1);
    drive(12'h000, 1'b0, 1'b0, 1'b1);
    drive(12'h000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("reset_odata", odata, 0);
    chk("reset_odval", odval, 0);
    chk("reset_oeof", oeof, 0);
  endtask

  // Monitor: every output pulse must match the head of the scoreboard queue.
  always @(negedge clk) begin
    exp_t e;
    if (odval) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_odval", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("odata", odata, e.data);
        chk("oeof", oeof, e.eof);
        chk("odval_cycle", cyc, e.at);
        out_log.push_back(int'(odata));
      end
    end else if (oeof) begin
      chk("oeof_without_odval", 1, 0);
    end
  end

  logic [11:0] frame[16];
  int          ref_log[$];

  initial begin
    idata = '0;
    idval = 1'b0;
    isof  = 1'b0;
    rst   = 1'b0;
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) pix[r][c] = 0;

    // Case 1: flat 0x800 frame
    reset_dut();
    out_log.delete();
    for (int i = 0; i < 16; i++) drive(12'h800, 1'b1, 1'b0, 1'b0);
    idle(3);
    chk("case1_count", out_log.size(), 4);
    foreach (out_log[i]) chk("case1_value", out_log[i], 12'h800);

    // Case 2: first quad 100/200/300/400, then G2=401
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 16; i++) frame[i] = 12'($urandom_range(0, 4095));
      frame[0] = 12'd100;
      frame[1] = 12'd200;
      frame[4] = 12'd300;
      frame[5] = (k == 0) ? 12'd400 : 12'd401;
      out_log.delete();
      for (int i = 0; i < 16; i++) drive(frame[i], 1'b1, 1'b0, 1'b0);
      idle(3);
      chk("case2_count", out_log.size(), 4);
      if (out_log.size() > 0) chk("case2_quad0", out_log[0], 250);
    end

    // Case 3: all ones, no overflow
    out_log.delete();
    for (int i = 0; i < 16; i++) drive(12'hFFF, 1'b1, 1'b0, 1'b0);
    idle(3);
    chk("case3_count", out_log.size(), 4);
    foreach (out_log[i]) chk("case3_value", out_log[i], 12'hFFF);

    // Case 4: gapless vs 1,0,1,0 valid pattern on the same data
    for (int i = 0; i < 16; i++) frame[i] = 12'($urandom_range(0, 4095));
    out_log.delete();
    for (int i = 0; i < 16; i++) drive(frame[i], 1'b1, 1'b0, 1'b0);
    idle(3);
    ref_log = out_log;
    out_log.delete();
    for (int i = 0; i < 16; i++) begin
      drive(frame[i], 1'b1, 1'b0, 1'b0);
      drive(12'h5A5, 1'b0, 1'b0, 1'b0);
    end
    idle(3);
    chk("case4_count", out_log.size(), 4);
    foreach (ref_log[i]) if (i < out_log.size()) chk("case4_same_seq", out_log[i], ref_log[i]);

    // Case 5: reset mid-frame, then a fresh frame
    for (int i = 0; i < 6; i++) drive(12'($urandom_range(0, 4095)), 1'b1, 1'b0, 1'b0);
    idle(2);
    reset_dut();
    out_log.delete();
    for (int i = 0; i < 16; i++) drive(12'($urandom_range(0, 4095)), 1'b1, 1'b0, 1'b0);
    idle(3);
    chk("case5_count", out_log.size(), 4);

    // Case 6: iSOF realigns after 5 beats
    for (int i = 0; i < 5; i++) drive(12'($urandom_range(0, 4095)), 1'b1, 1'b0, 1'b0);
    idle(2);
    out_log.delete();
    for (int i = 0; i < 16; i++) drive(12'($urandom_range(0, 4095)), 1'b1, i == 0, 1'b0);
    idle(3);
    chk("case6_count", out_log.size(), 4);

    // iSOF without a valid beat also realigns
    for (int i = 0; i < 3; i++) drive(12'($urandom_range(0, 4095)), 1'b1, 1'b0, 1'b0);
    drive(12'h000, 1'b0, 1'b1, 1'b0);
    out_log.delete();
    for (int i = 0; i < 16; i++) drive(12'($urandom_range(0, 4095)), 1'b1, 1'b0, 1'b0);
    idle(3);
    chk("sof_idle_count", out_log.size(), 4);

    // Randomized frames with random gaps and occasional realignment
    for (int f = 0; f < 40; f++) begin
      for (int i = 0; i < 16; i++) begin
        if ($urandom_range(0, 2) == 0) drive(12'($urandom_range(0, 4095)), 1'b0, 1'b0, 1'b0);
        drive(12'($urandom_range(0, 4095)), 1'b1, $urandom_range(0, 39) == 0, 1'b0);
      end
    end
    idle(4);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
